cu_vertex_request_sequencer: RTL and testbench
==============================================

Name: cu_vertex_request_sequencer

Overview:
- Sequences vertex-array read requests for one compute unit.
- Given a vertex range, it emits paired read commands for the inverse out-degree and inverse edge-index arrays. Each command covers one cacheline chunk, sized to the power-of-2 rule of the read-command channel.
- Sits between the CU control register block and the read command buffer. Throttled by a credit counter of outstanding responses.

Parameters:
- VERTEX_SIZE, 4: bytes per vertex element (power of 2).
- CACHELINE_BYTES, 128: maximum command size in bytes.
- MAX_OUTSTANDING, 8: maximum commands awaiting response.
- ADDR_WIDTH, 64: address width in bits.

Ports:
- clock  in  1  single clock; all state on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- enabled  in  1  CU enable; when low, held in SEND_VERTEX_INIT.
- start  in  1  one-cycle pulse; latches job inputs.
- vertex_start  in  32  first vertex index.
- vertex_num  in  32  vertex count of the job.
- base_inv_out_degree  in  ADDR_WIDTH  byte base address of array.
- base_inv_edges_idx  in  ADDR_WIDTH  byte base address of array.
- cmd_ready  in  1  read command buffer not full.
- cmd_valid  out  1  command present.
- cmd_address  out  ADDR_WIDTH  byte address of chunk.
- cmd_size  out  12  request bytes: 1, 2, 4 … 128, or 0.
- cmd_array  out  array_struct_type  INV_OUT_DEGREE or INV_EDGES_IDX.
- rsp_done  in  1  one pulse per completed command.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when the last response returns.

Behaviour:
- Reset: cmd_valid=0, cmd_address=0, cmd_size=0, cmd_array=STRUCT_INVALID, busy=0, done=0, credits=0. State goes to SEND_VERTEX_RESET.
- Reset asserted mid-job: all counters clear and the in-flight command is dropped. No done pulse is produced.
- States:
  - RESET → INIT unconditionally.
  - INIT → IDLE when enabled.
  - IDLE → START_REQ on start.
    - Latch vertex_start and vertex_num.
    - remaining = vertex_num; offset = vertex_start << log2(VERTEX_SIZE); busy=1.
    - If vertex_num=0: pulse done on the next cycle and return to IDLE.
  - START_REQ → CALC_SIZE when remaining>0 and outstanding ≤ MAX_OUTSTANDING-2. Otherwise stay.
  - CALC_SIZE, one cycle:
    - chunk = min(remaining, CACHELINE_BYTES/VERTEX_SIZE).
    - bytes = chunk << log2(VERTEX_SIZE).
    - size = smallest power of 2 ≥ bytes, capped at CACHELINE_BYTES. Examples: 12 bytes → 16; 0 → 0.
  - → SEND_VERTEX_INV_OUT_DEGREE: cmd_valid=1, address = base_inv_out_degree + offset. Advance when cmd_ready.
  - → SEND_VERTEX_INV_EDGES_IDX: same size, address = base_inv_edges_idx + offset. On cmd_ready: remaining -= chunk, offset += bytes.
    - Next state is START_REQ if remaining>0, else WAIT_VERTEX_DATA.
  - WAIT_VERTEX_DATA → IDLE when outstanding==0. Pulse done, clear busy.
- Handshake: a command transfers on cmd_valid & cmd_ready. cmd_* fields stay stable while cmd_valid=1 & !cmd_ready.
- Latency: first cmd_valid appears 2 cycles after start, then one command per cycle when ready.
- Credits: outstanding += 1 per transfer, -= 1 per rsp_done.
  - Simultaneous transfer and rsp_done leaves the count unchanged.
  - Never exceeds MAX_OUTSTANDING.
  - rsp_done with outstanding==0 is ignored.
- Address arithmetic is in ADDR_WIDTH bits, wrap-around modulo 2^ADDR_WIDTH. offset is ADDR_WIDTH wide.
- start outside IDLE is ignored.
- enabled deasserted mid-job: finish the current SEND_ state, drain to WAIT_VERTEX_DATA, then go to INIT without a done pulse.

Optional Feature:
- Macro: CU_VERTEX_REQ_PERF_EN.
- With the macro, two extra outputs are added:
  - stall_ready_cycles (32): cycles with cmd_valid & !cmd_ready.
  - stall_credit_cycles (32): cycles in START_REQ blocked by credits.
  - Both clear on start and saturate at all-ones.
- Without the macro, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package CU_PKG holds:
  - array_struct_type and the vertex_struct_state enum (existing).
  - cmd_size_calculate, generalised to take a byte count.
  - A new constant VERTEX_CHUNK_MAX = CACHELINE_BYTES/VERTEX_SIZE.
- One natural sub-module: cu_credit_counter, a saturating up/down counter with a limit-check output. It is reused by the edge sequencer.

Test Plan:
- Job vertex_start=0, vertex_num=64, bases 0x1000 / 0x8000, cmd_ready=1:
  - Commands (0x1000,128,OUT), (0x8000,128,EDGES), (0x1080,128,OUT), (0x8080,128,EDGES).
  - done follows 4 rsp_done pulses.
- vertex_num=35, vertex_start=2:
  - Chunks of 32 then 3 vertices; sizes 128 then 16.
  - Second-chunk addresses base+0x88.
- cmd_ready held low 5 cycles during the first command → cmd_* fields stable and no duplicate transfer.
- MAX_OUTSTANDING=2, vertex_num=96, no rsp_done → stalls in START_REQ after 2 commands.
  - Each rsp_done pair releases the next pair; done after the 6th response.
- vertex_num=0 → no commands; done pulse 1 cycle after start.
- rstn low after 3 command transfers → all outputs at reset values; a new start runs cleanly with outstanding=0.

Source files
------------

// File: rtl/cu_vertex_request_sequencer_pkg.sv
// Shared types and helpers for the compute-unit read sequencers: array tags,
// vertex sequencer states and the power-of-2 read-command size rule.
package cu_vertex_request_sequencer_pkg;

  localparam int VERTEX_SIZE_DEFAULT     = 4;
  localparam int CACHELINE_BYTES_DEFAULT = 128;
  localparam int VERTEX_CHUNK_MAX        = CACHELINE_BYTES_DEFAULT / VERTEX_SIZE_DEFAULT;

  typedef enum logic [1:0] {
    STRUCT_INVALID,
    STRUCT_INV_OUT_DEGREE,
    STRUCT_INV_EDGES_IDX
  } array_struct_type;

  typedef enum logic [2:0] {
    SEND_VERTEX_RESET,
    SEND_VERTEX_INIT,
    SEND_VERTEX_IDLE,
    SEND_VERTEX_START_REQ,
    SEND_VERTEX_CALC_SIZE,
    SEND_VERTEX_INV_OUT_DEGREE,
    SEND_VERTEX_INV_EDGES_IDX,
    WAIT_VERTEX_DATA
  } vertex_struct_state;

  // Smallest power of two covering nbytes, never above cap; zero bytes gives zero.
  function automatic logic [11:0] cmd_size_calculate(input logic [31:0] nbytes,
                                                     input logic [31:0] cap);
    logic [31:0] p;
    p = 32'd0;
    if (nbytes != 32'd0) begin
      p = 32'd1;
      for (int i = 0; i < 12; i++) begin
        if (p < nbytes && p < cap) p = p << 1;
      end
    end
    return p[11:0];
  endfunction

endpackage

// File: rtl/cu_vertex_request_sequencer_if.sv
// Read-command channel from a sequencer to the read command buffer (valid/ready).
interface cu_vertex_request_sequencer_if #(parameter int ADDR_WIDTH = 64);
  import cu_vertex_request_sequencer_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_address;
  logic [11:0]           cmd_size;
  array_struct_type      cmd_array;

  modport master (output cmd_valid, cmd_address, cmd_size, cmd_array, input cmd_ready);
  modport slave  (input cmd_valid, cmd_address, cmd_size, cmd_array, output cmd_ready);
endinterface

// File: rtl/cu_credit_counter.sv
// Saturating up/down count of outstanding commands; has_room flags HEADROOM free slots.
// Registered count, 1-cycle update; inc+dec together hold, dec at zero is ignored.
module cu_credit_counter #(
  parameter int MAX      = 8,
  parameter int HEADROOM = 2,
  parameter int W        = $clog2(MAX + 1)
) (
  input  logic         clock,
  input  logic         rstn,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         has_room
);

  logic dec_eff;

  assign dec_eff  = dec && (count != '0);
  assign has_room = (int'(count) + HEADROOM) <= MAX;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else begin
      case ({inc, dec_eff})
        2'b10:   if (count != W'(MAX)) count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cu_vertex_request_sequencer.sv
// Emits paired inv-out-degree / inv-edges-idx read commands per cacheline chunk of a vertex range.
// First cmd_valid 2 cycles after start; holds cmd_* under !cmd_ready; credit-throttled. Perf counters: CU_VERTEX_REQ_PERF_EN.
module cu_vertex_request_sequencer
  import cu_vertex_request_sequencer_pkg::*;
#(
  parameter int VERTEX_SIZE     = VERTEX_SIZE_DEFAULT,
  parameter int CACHELINE_BYTES = CACHELINE_BYTES_DEFAULT,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ADDR_WIDTH      = 64
) (
  input  logic                         clock,
  input  logic                         rstn,
  input  logic                         enabled,
  input  logic                         start,
  input  logic [31:0]                  vertex_start,
  input  logic [31:0]                  vertex_num,
  input  logic [ADDR_WIDTH-1:0]        base_inv_out_degree,
  input  logic [ADDR_WIDTH-1:0]        base_inv_edges_idx,
  cu_vertex_request_sequencer_if.master cmd,
  input  logic                         rsp_done,
  output logic                         busy,
  output logic                         done
`ifdef CU_VERTEX_REQ_PERF_EN
  ,
  output logic [31:0]                  stall_ready_cycles,
  output logic [31:0]                  stall_credit_cycles
`endif
);

  localparam int VS_LOG2   = $clog2(VERTEX_SIZE);
  localparam int CHUNK_MAX = CACHELINE_BYTES / VERTEX_SIZE;
  localparam int CW        = $clog2(MAX_OUTSTANDING + 1);

  vertex_struct_state    state;
  logic [31:0]           remaining;
  logic [31:0]           chunk;
  logic [31:0]           bytes;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  aborted;
  logic [CW-1:0]         outstanding;
  logic                  has_room;
  logic [31:0]           chunk_c;
  logic [31:0]           bytes_c;
  logic                  xfer;

  assign xfer    = cmd.cmd_valid && cmd.cmd_ready;
  assign chunk_c = (remaining < 32'(CHUNK_MAX)) ? remaining : 32'(CHUNK_MAX);
  assign bytes_c = chunk_c << VS_LOG2;

  cu_credit_counter #(.MAX(MAX_OUTSTANDING), .HEADROOM(2), .W(CW)) u_credits (
    .clock    (clock),
    .rstn     (rstn),
    .inc      (xfer),
    .dec      (rsp_done),
    .count    (outstanding),
    .has_room (has_room)
  );

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state           <= SEND_VERTEX_RESET;
      remaining       <= '0;
      chunk           <= '0;
      bytes           <= '0;
      offset          <= '0;
      aborted         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      cmd.cmd_valid   <= 1'b0;
      cmd.cmd_address <= '0;
      cmd.cmd_size    <= '0;
      cmd.cmd_array   <= STRUCT_INVALID;
    end else begin
      done <= 1'b0;
      if (busy && !enabled) aborted <= 1'b1;
      case (state)
        SEND_VERTEX_RESET: state <= SEND_VERTEX_INIT;
        SEND_VERTEX_INIT:  if (enabled) state <= SEND_VERTEX_IDLE;
        SEND_VERTEX_IDLE: begin
          if (!enabled) begin
            state <= SEND_VERTEX_INIT;
          end else if (start) begin
            remaining <= vertex_num;
            offset    <= ADDR_WIDTH'(vertex_start) << VS_LOG2;
            aborted   <= 1'b0;
            busy      <= 1'b1;
            state     <= SEND_VERTEX_START_REQ;
          end
        end
        SEND_VERTEX_START_REQ: begin
          if (remaining == 32'd0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= SEND_VERTEX_IDLE;
          end else if (!enabled) begin
            state <= WAIT_VERTEX_DATA;
          end else if (has_room) begin
            state <= SEND_VERTEX_CALC_SIZE;
          end
        end
        SEND_VERTEX_CALC_SIZE: begin
          chunk           <= chunk_c;
          bytes           <= bytes_c;
          cmd.cmd_size    <= cmd_size_calculate(bytes_c, 32'(CACHELINE_BYTES));
          cmd.cmd_address <= base_inv_out_degree + offset;
          cmd.cmd_array   <= STRUCT_INV_OUT_DEGREE;
          cmd.cmd_valid   <= 1'b1;
          state           <= SEND_VERTEX_INV_OUT_DEGREE;
        end
        SEND_VERTEX_INV_OUT_DEGREE: begin
          if (cmd.cmd_ready) begin
            cmd.cmd_address <= base_inv_edges_idx + offset;
            cmd.cmd_array   <= STRUCT_INV_EDGES_IDX;
            state           <= SEND_VERTEX_INV_EDGES_IDX;
          end
        end
        SEND_VERTEX_INV_EDGES_IDX: begin
          if (cmd.cmd_ready) begin
            cmd.cmd_valid <= 1'b0;
            remaining     <= remaining - chunk;
            offset        <= offset + ADDR_WIDTH'(bytes);
            // A disable lets the pair complete, then drains without more chunks.
            if (remaining != chunk && enabled && !aborted) state <= SEND_VERTEX_START_REQ;
            else                                            state <= WAIT_VERTEX_DATA;
          end
        end
        WAIT_VERTEX_DATA: begin
          if (outstanding == '0) begin
            busy <= 1'b0;
            if (aborted || !enabled) begin
              state <= SEND_VERTEX_INIT;
            end else begin
              done  <= 1'b1;
              state <= SEND_VERTEX_IDLE;
            end
          end
        end
        default: state <= SEND_VERTEX_RESET;
      endcase
    end
  end

`ifdef CU_VERTEX_REQ_PERF_EN
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      stall_ready_cycles  <= '0;
      stall_credit_cycles <= '0;
    end else if (start && state == SEND_VERTEX_IDLE) begin
      stall_ready_cycles  <= '0;
      stall_credit_cycles <= '0;
    end else begin
      if (cmd.cmd_valid && !cmd.cmd_ready && stall_ready_cycles != '1)
        stall_ready_cycles <= stall_ready_cycles + 1'b1;
      if (state == SEND_VERTEX_START_REQ && enabled && remaining != 32'd0 && !has_room &&
          stall_credit_cycles != '1)
        stall_credit_cycles <= stall_credit_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cu_vertex_request_sequencer.sv
// Directed bench: default instance plus a MAX_OUTSTANDING=2 instance for credit stalls.
`timescale 1ns/1ps
module tb_cu_vertex_request_sequencer;
  import cu_vertex_request_sequencer_pkg::*;

  localparam int AW = 64;

  logic          clock = 1'b0;
  logic          rstn, enabled, start, start2, rsp_done, rsp_done2;
  logic [31:0]   vertex_start, vertex_num;
  logic [AW-1:0] base_out, base_edges;
  logic          busy, done, busy2, done2;
`ifdef CU_VERTEX_REQ_PERF_EN
  logic [31:0]   sr, sc, sr2, sc2;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int done2_cnt = 0;
  logic [AW-1:0]    q_addr[$], q2_addr[$];
  logic [11:0]      q_size[$], q2_size[$];
  array_struct_type q_arr[$],  q2_arr[$];

  cu_vertex_request_sequencer_if #(.ADDR_WIDTH(AW)) cmd_if ();
  cu_vertex_request_sequencer_if #(.ADDR_WIDTH(AW)) cmd2_if ();

  cu_vertex_request_sequencer dut (
    .clock(clock), .rstn(rstn), .enabled(enabled), .start(start),
    .vertex_start(vertex_start), .vertex_num(vertex_num),
    .base_inv_out_degree(base_out), .base_inv_edges_idx(base_edges),
    .cmd(cmd_if), .rsp_done(rsp_done), .busy(busy), .done(done)
`ifdef CU_VERTEX_REQ_PERF_EN
    , .stall_ready_cycles(sr), .stall_credit_cycles(sc)
`endif
  );

  cu_vertex_request_sequencer #(.MAX_OUTSTANDING(2)) dut2 (
    .clock(clock), .rstn(rstn), .enabled(enabled), .start(start2),
    .vertex_start(vertex_start), .vertex_num(vertex_num),
    .base_inv_out_degree(base_out), .base_inv_edges_idx(base_edges),
    .cmd(cmd2_if), .rsp_done(rsp_done2), .busy(busy2), .done(done2)
`ifdef CU_VERTEX_REQ_PERF_EN
    , .stall_ready_cycles(sr2), .stall_credit_cycles(sc2)
`endif
  );

  always #5 clock = ~clock;

  // Inputs only change just after posedge, so a negedge sample sees the transfer of the next edge.
  always @(negedge clock) begin
    if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      q_addr.push_back(cmd_if.cmd_address);
      q_size.push_back(cmd_if.cmd_size);
      q_arr.push_back(cmd_if.cmd_array);
    end
    if (cmd2_if.cmd_valid && cmd2_if.cmd_ready) begin
      q2_addr.push_back(cmd2_if.cmd_address);
      q2_size.push_back(cmd2_if.cmd_size);
      q2_arr.push_back(cmd2_if.cmd_array);
    end
    if (done)  done_cnt++;
    if (done2) done2_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic go(input int which, input logic [31:0] vs, input logic [31:0] vn);
    vertex_start = vs;
    vertex_num   = vn;
    if (which == 0) start = 1'b1; else start2 = 1'b1;
    tick();
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_xfers(input int which, input int n, input int budget);
    for (int i = 0; i < budget && ((which == 0) ? q_addr.size() : q2_addr.size()) < n; i++) tick();
  endtask

  task automatic wait_done(input int which, input int target, input int budget);
    for (int i = 0; i < budget && ((which == 0) ? done_cnt : done2_cnt) < target; i++) tick();
  endtask

  task automatic pulse_rsp(input int which, input int n);
    if (which == 0) rsp_done = 1'b1; else rsp_done2 = 1'b1;
    repeat (n) tick();
    rsp_done  = 1'b0;
    rsp_done2 = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enabled = 1'b0; start = 1'b0; start2 = 1'b0;
    rsp_done = 1'b0; rsp_done2 = 1'b0; vertex_start = '0; vertex_num = '0;
    base_out = 64'h1000; base_edges = 64'h8000;
    cmd_if.cmd_ready = 1'b1; cmd2_if.cmd_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({cmd_if.cmd_valid, cmd_if.cmd_address, cmd_if.cmd_size} !== {1'b0, 64'h0, 12'h0})
      $display("FAIL reset_cmd: got valid=%0b addr=%0h size=%0d want 0/0/0",
               cmd_if.cmd_valid, cmd_if.cmd_address, cmd_if.cmd_size);
    else n_pass++;
    n_checks++;
    if (cmd_if.cmd_array !== STRUCT_INVALID)
      $display("FAIL reset_array: got %0d want %0d", cmd_if.cmd_array, STRUCT_INVALID);
    else n_pass++;
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done: got %b want 00", {busy, done});
    else n_pass++;
    rstn = 1'b1; enabled = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    logic [AW-1:0]    ea[4];
    array_struct_type et;
    int b, d;
    ea = '{64'h1000, 64'h8000, 64'h1080, 64'h8080};
    b = q_addr.size(); d = done_cnt;
    cmd_if.cmd_ready = 1'b1;
    go(0, 32'd0, 32'd64);
    n_checks++;
    if ({busy, cmd_if.cmd_valid} !== 2'b10)
      $display("FAIL basic_after_start: got busy,valid=%b want 10", {busy, cmd_if.cmd_valid});
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (cmd_if.cmd_valid !== 1'b1) $display("FAIL basic_first_valid_latency: got %0b want 1", cmd_if.cmd_valid);
    else n_pass++;
    wait_xfers(0, b + 4, 40);
    n_checks++;
    if (q_addr.size() !== b + 4) $display("FAIL basic_xfer_count: got %0d want %0d", q_addr.size() - b, 4);
    else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        et = (i % 2 == 0) ? STRUCT_INV_OUT_DEGREE : STRUCT_INV_EDGES_IDX;
        n_checks++;
        if (q_addr[b+i] !== ea[i] || q_size[b+i] !== 12'd128 || q_arr[b+i] !== et)
          $display("FAIL basic_cmd%0d: got %0h/%0d/%0d want %0h/128/%0d",
                   i, q_addr[b+i], q_size[b+i], q_arr[b+i], ea[i], et);
        else n_pass++;
      end
    end
    repeat (3) tick();
    n_checks++;
    if (done_cnt !== d) $display("FAIL basic_no_early_done: got %0d want %0d", done_cnt, d);
    else n_pass++;
    pulse_rsp(0, 4);
    wait_done(0, d + 1, 20);
    repeat (2) tick();
    n_checks++;
    if (done_cnt !== d + 1 || busy !== 1'b0)
      $display("FAIL basic_done: got done_cnt=%0d busy=%0b want %0d 0", done_cnt - d, busy, 1);
    else n_pass++;
  endtask

  task automatic test_partial();
    logic [AW-1:0] ea[4];
    logic [11:0]   es[4];
    int b, d;
    ea = '{64'h1008, 64'h8008, 64'h1088, 64'h8088};
    es = '{12'd128, 12'd128, 12'd16, 12'd16};
    b = q_addr.size(); d = done_cnt;
    go(0, 32'd2, 32'd35);
    wait_xfers(0, b + 4, 40);
    n_checks++;
    if (q_addr.size() !== b + 4) $display("FAIL partial_xfer_count: got %0d want 4", q_addr.size() - b);
    else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (q_addr[b+i] !== ea[i] || q_size[b+i] !== es[i])
          $display("FAIL partial_cmd%0d: got %0h/%0d want %0h/%0d", i, q_addr[b+i], q_size[b+i], ea[i], es[i]);
        else n_pass++;
      end
    end
    pulse_rsp(0, 4);
    wait_done(0, d + 1, 20);
    n_checks++;
    if (done_cnt !== d + 1) $display("FAIL partial_done: got %0d want 1", done_cnt - d);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int b, d;
    b = q_addr.size(); d = done_cnt;
    cmd_if.cmd_ready = 1'b0;
    go(0, 32'd0, 32'd64);
    for (int i = 0; i < 10 && cmd_if.cmd_valid !== 1'b1; i++) tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_address !== 64'h1000 ||
          cmd_if.cmd_size !== 12'd128 || cmd_if.cmd_array !== STRUCT_INV_OUT_DEGREE)
        $display("FAIL bp_hold_cycle%0d: got %0b/%0h/%0d/%0d want 1/1000/128/%0d", i, cmd_if.cmd_valid,
                 cmd_if.cmd_address, cmd_if.cmd_size, cmd_if.cmd_array, STRUCT_INV_OUT_DEGREE);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (q_addr.size() !== b) $display("FAIL bp_no_xfer_while_stalled: got %0d want 0", q_addr.size() - b);
    else n_pass++;
    cmd_if.cmd_ready = 1'b1;
    wait_xfers(0, b + 4, 40);
    repeat (4) tick();
    n_checks++;
    if (q_addr.size() !== b + 4) $display("FAIL bp_xfer_count: got %0d want 4", q_addr.size() - b);
    else begin
      n_pass++;
      n_checks++;
      if (q_addr[b] !== 64'h1000 || q_addr[b+1] !== 64'h8000)
        $display("FAIL bp_no_duplicate: got %0h,%0h want 1000,8000", q_addr[b], q_addr[b+1]);
      else n_pass++;
    end
    pulse_rsp(0, 4);
    wait_done(0, d + 1, 20);
    n_checks++;
    if (done_cnt !== d + 1) $display("FAIL bp_done: got %0d want 1", done_cnt - d);
    else n_pass++;
  endtask

  task automatic test_credit_stall();
    int b, d;
    b = q2_addr.size(); d = done2_cnt;
    go(1, 32'd0, 32'd96);
    repeat (20) tick();
    n_checks++;
    if (q2_addr.size() !== b + 2 || busy2 !== 1'b1)
      $display("FAIL credit_stall_first: got xfers=%0d busy=%0b want 2 1", q2_addr.size() - b, busy2);
    else n_pass++;
    pulse_rsp(1, 2);
    repeat (20) tick();
    n_checks++;
    if (q2_addr.size() !== b + 4) $display("FAIL credit_release_second: got %0d want 4", q2_addr.size() - b);
    else begin
      n_pass++;
      n_checks++;
      if (q2_addr[b+2] !== 64'h1080) $display("FAIL credit_addr3: got %0h want 1080", q2_addr[b+2]);
      else n_pass++;
    end
    pulse_rsp(1, 2);
    repeat (20) tick();
    n_checks++;
    if (q2_addr.size() !== b + 6 || done2_cnt !== d)
      $display("FAIL credit_release_third: got xfers=%0d done=%0d want 6 0", q2_addr.size() - b, done2_cnt - d);
    else n_pass++;
    n_checks++;
    if (q2_addr.size() >= b + 6 && q2_addr[b+5] !== 64'h8100)
      $display("FAIL credit_addr6: got %0h want 8100", q2_addr[b+5]);
    else n_pass++;
    pulse_rsp(1, 2);
    wait_done(1, d + 1, 20);
    n_checks++;
    if (done2_cnt !== d + 1 || busy2 !== 1'b0)
      $display("FAIL credit_done: got done=%0d busy=%0b want 1 0", done2_cnt - d, busy2);
    else n_pass++;
  endtask

  task automatic test_zero();
    int b, d;
    b = q_addr.size(); d = done_cnt;
    go(0, 32'd5, 32'd0);
    tick();
    n_checks++;
    if (done !== 1'b1) $display("FAIL zero_done_pulse: got %0b want 1", done);
    else n_pass++;
    repeat (4) tick();
    n_checks++;
    if (done_cnt !== d + 1 || q_addr.size() !== b || busy !== 1'b0)
      $display("FAIL zero_no_cmds: got done=%0d xfers=%0d busy=%0b want 1 0 0", done_cnt - d, q_addr.size() - b, busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_job();
    int b, d;
    b = q_addr.size(); d = done_cnt;
    go(0, 32'd0, 32'd96);
    wait_xfers(0, b + 3, 40);
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({cmd_if.cmd_valid, cmd_if.cmd_address, cmd_if.cmd_size, busy, done} !== {1'b0, 64'h0, 12'h0, 2'b00} ||
        cmd_if.cmd_array !== STRUCT_INVALID)
      $display("FAIL midreset_outputs: got valid=%0b addr=%0h size=%0d busy=%0b arr=%0d want all reset",
               cmd_if.cmd_valid, cmd_if.cmd_address, cmd_if.cmd_size, busy, cmd_if.cmd_array);
    else n_pass++;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (done_cnt !== d) $display("FAIL midreset_no_done: got %0d want 0", done_cnt - d);
    else n_pass++;
    b = q_addr.size();
    go(0, 32'd0, 32'd64);
    wait_xfers(0, b + 4, 40);
    n_checks++;
    if (q_addr.size() !== b + 4 || q_addr[b] !== 64'h1000)
      $display("FAIL midreset_rerun_cmds: got xfers=%0d want 4 from 1000", q_addr.size() - b);
    else n_pass++;
    pulse_rsp(0, 4);
    wait_done(0, d + 1, 20);
    n_checks++;
    if (done_cnt !== d + 1) $display("FAIL midreset_rerun_done: got %0d want 1", done_cnt - d);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_credit_stall();
    test_zero();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
